// File: rtl/sopc_intc.sv
// Memory-mapped interrupt controller: per-source edge/level capture, mask,
// registered masked-pending vector and a lowest-index ID register.
module sopc_intc #(
    parameter int          NUM_SRC   = 6,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               ce_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [3:0]         sel_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic [NUM_SRC-1:0] int_o,
    output logic               irq_o
);

    // Registers are kept 32 bits wide; bits above NUM_SRC are forced to zero.
    localparam logic [31:0] IMPL_MASK = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'h1 << NUM_SRC) - 32'h1);

    localparam logic [1:0] OFS_PEND = 2'd0;
    localparam logic [1:0] OFS_MASK = 2'd1;
    localparam logic [1:0] OFS_MODE = 2'd2;
    localparam logic [1:0] OFS_ID   = 2'd3;

    function automatic logic [5:0] lowest_id(input logic [31:0] v);
        logic [5:0] id;
        id = 6'd0;
        for (int i = 31; i >= 0; i--) begin
            id = v[i] ? 6'(i + 1) : id;
        end
        return id;
    endfunction

    logic               sel_s;
    logic               wr_s;
    logic [1:0]         ofs_s;
    logic [31:0]        wmask_s;
    logic [31:0]        src_ext_s;
    logic [31:0]        edge_s;
    logic [31:0]        w1c_s;
    logic [31:0]        pm_s;
    logic               unused_addr_s;

    logic [31:0]        pending_q, pending_d;
    logic [31:0]        mask_q,    mask_d;
    logic [31:0]        mode_q,    mode_d;
    logic [31:0]        src_q,     src_d;
    logic [NUM_SRC-1:0] int_q,     int_d;
    logic               irq_q,     irq_d;

    assign sel_s         = ce_i && (addr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_s          = sel_s && we_i;
    assign ofs_s         = addr_i[3:2];
    assign unused_addr_s = ^addr_i[1:0];

    // Byte-enable expansion and zero-extension of the raw sources.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            wmask_s[8*b +: 8] = {8{sel_i[b]}};
        end
        src_ext_s                = 32'h0;
        src_ext_s[NUM_SRC-1:0]   = src_i;
    end

    // Bus write decode for MASK, MODE and the PENDING clear vector.
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        w1c_s  = 32'h0;
        if (wr_s) begin
            case (ofs_s)
                OFS_PEND: w1c_s  = data_i & wmask_s & IMPL_MASK;
                OFS_MASK: mask_d = ((mask_q & ~wmask_s) | (data_i & wmask_s)) & IMPL_MASK;
                OFS_MODE: mode_d = ((mode_q & ~wmask_s) | (data_i & wmask_s)) & IMPL_MASK;
                OFS_ID:   w1c_s  = 32'h0;
                default:  w1c_s  = 32'h0;
            endcase
        end else begin
            w1c_s = 32'h0;
        end
    end

    // Pending update: the mode written at this edge already governs capture,
    // and a same-edge event beats a clear.
    always_comb begin
        edge_s    = src_ext_s & ~src_q;
        pending_d = ((mode_d & (edge_s | (pending_q & ~w1c_s))) |
                     (~mode_d & src_ext_s)) & IMPL_MASK;
        src_d     = src_ext_s;
        pm_s      = pending_q & mask_q;
        int_d     = pm_s[NUM_SRC-1:0];
        irq_d     = |pm_s;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= 32'h0;
            mask_q    <= 32'h0;
            mode_q    <= 32'h0;
            src_q     <= 32'h0;
            int_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            int_q     <= int_d;
            irq_q     <= irq_d;
        end
    end

    // Combinational register read; zero when unselected or writing.
    always_comb begin
        data_o = 32'h0;
        if (sel_s && !we_i) begin
            case (ofs_s)
                OFS_PEND: data_o = pending_q;
                OFS_MASK: data_o = mask_q;
                OFS_MODE: data_o = mode_q;
                OFS_ID:   data_o = {26'h0, lowest_id(pm_s)};
                default:  data_o = 32'h0;
            endcase
        end else begin
            data_o = 32'h0;
        end
    end

    assign int_o = int_q;
    assign irq_o = irq_q;

endmodule

// File: tb/tb_sopc_intc.sv
// Directed bench for sopc_intc: a 6-source instance for the main scenarios
// and a 32-source instance for the top-index and mid-run reset cases.
module tb_sopc_intc;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam logic [31:0] PEND  = BASE + 32'h0;
    localparam logic [31:0] MASKR = BASE + 32'h4;
    localparam logic [31:0] MODER = BASE + 32'h8;
    localparam logic [31:0] IDR   = BASE + 32'hC;

    logic        clk;
    logic        rst_a, rst_b;
    logic [5:0]  src_a;
    logic [31:0] src_b;
    logic        ce_a, ce_b, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] dout_a, dout_b;
    logic [5:0]  int_a;
    logic [31:0] int_b;
    logic        irq_a, irq_b;

    logic        tgt;
    logic [31:0] rd;
    logic [31:0] wr_dout;
    int          n_tests;
    int          n_fail;

    sopc_intc #(.NUM_SRC(6), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .rst(rst_a), .src_i(src_a), .ce_i(ce_a), .we_i(we),
        .addr_i(addr), .sel_i(sel), .data_i(wdata), .data_o(dout_a),
        .int_o(int_a), .irq_o(irq_a)
    );

    sopc_intc #(.NUM_SRC(32), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .rst(rst_b), .src_i(src_b), .ce_i(ce_b), .we_i(we),
        .addr_i(addr), .sel_i(sel), .data_i(wdata), .data_o(dout_b),
        .int_o(int_b), .irq_o(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        addr  = a;
        wdata = d;
        sel   = s;
        we    = 1'b1;
        ce_a  = (tgt == 1'b0);
        ce_b  = (tgt == 1'b1);
        #1;
        wr_dout = tgt ? dout_b : dout_a;
        tick();
        ce_a = 1'b0;
        ce_b = 1'b0;
        we   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        ce_a = (tgt == 1'b0);
        ce_b = (tgt == 1'b1);
        #1;
        d    = tgt ? dout_b : dout_a;
        ce_a = 1'b0;
        ce_b = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tgt     = 1'b0;
        rst_a   = 1'b0;
        rst_b   = 1'b0;
        src_a   = 6'h0;
        src_b   = 32'h0;
        ce_a    = 1'b0;
        ce_b    = 1'b0;
        we      = 1'b0;
        addr    = 32'h0;
        wdata   = 32'h0;
        sel     = 4'h0;
        tick();
        tick();

        // Register contents while reset is held.
        bus_read(PEND,  rd); check_eq("rst_pend", rd, 32'h0);
        bus_read(MASKR, rd); check_eq("rst_mask", rd, 32'h0);
        bus_read(MODER, rd); check_eq("rst_mode", rd, 32'h0);
        bus_read(IDR,   rd); check_eq("rst_id",   rd, 32'h0);
        check_eq("rst_int", {26'h0, int_a}, 32'h0);
        check_eq("rst_irq", {31'h0, irq_a}, 32'h0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        // Edge mode on all sources; unimplemented MODE bits stay 0.
        bus_write(MODER, 32'hFFFF_FFFF, 4'hF);
        check_eq("wr_dout_zero", wr_dout, 32'h0);
        bus_read(MODER, rd); check_eq("mode_impl", rd, 32'h3F);
        bus_write(MASKR, 32'h01, 4'hF);
        bus_read(MASKR, rd); check_eq("mask_rd", rd, 32'h01);

        // One-cycle pulse on source 0: pending after edge k, int one edge later.
        src_a = 6'h01;
        tick();
        src_a = 6'h00;
        bus_read(PEND, rd); check_eq("pulse_pend", rd, 32'h01);
        check_eq("pulse_int_k", {26'h0, int_a}, 32'h0);
        tick();
        check_eq("pulse_int_k1", {26'h0, int_a}, 32'h01);
        check_eq("pulse_irq_k1", {31'h0, irq_a}, 32'h1);
        bus_read(IDR, rd); check_eq("pulse_id", rd, 32'd1);

        // W1C with no byte enabled does nothing; with all bytes it clears.
        bus_write(PEND, 32'h01, 4'h0);
        bus_read(PEND, rd); check_eq("w1c_sel0", rd, 32'h01);
        bus_write(PEND, 32'h01, 4'hF);
        bus_read(PEND, rd); check_eq("w1c_pend", rd, 32'h0);
        check_eq("w1c_int_lag", {26'h0, int_a}, 32'h01);
        tick();
        check_eq("w1c_int", {26'h0, int_a}, 32'h0);
        check_eq("w1c_irq", {31'h0, irq_a}, 32'h0);

        // Edge event and clear on the same edge: the event wins.
        src_a = 6'h04;
        bus_write(PEND, 32'h04, 4'hF);
        bus_read(PEND, rd); check_eq("set_wins", rd, 32'h04);
        src_a = 6'h00;
        bus_write(PEND, 32'h04, 4'hF);
        bus_read(PEND, rd); check_eq("clr_bit2", rd, 32'h0);

        // Level mode: pending tracks sources, W1C has no effect.
        bus_write(MODER, 32'h0, 4'hF);
        bus_write(MASKR, 32'h3F, 4'hF);
        src_a = 6'b001100;
        tick();
        bus_read(PEND, rd); check_eq("lvl_pend", rd, 32'h0C);
        bus_read(IDR, rd);  check_eq("lvl_id", rd, 32'd3);
        bus_write(PEND, 32'h0C, 4'hF);
        bus_read(PEND, rd); check_eq("lvl_w1c", rd, 32'h0C);
        src_a = 6'h00;
        tick();
        bus_read(PEND, rd); check_eq("lvl_fall", rd, 32'h0);

        // Masking a pending source drops int one edge later, pending kept.
        bus_write(MODER, 32'h3F, 4'hF);
        src_a = 6'h02;
        tick();
        bus_read(PEND, rd); check_eq("m_pend", rd, 32'h02);
        tick();
        check_eq("m_int_on", {26'h0, int_a}, 32'h02);
        bus_write(MASKR, 32'h0, 4'hF);
        check_eq("m_int_lag", {26'h0, int_a}, 32'h02);
        tick();
        check_eq("m_int_off", {26'h0, int_a}, 32'h0);
        bus_read(PEND, rd); check_eq("m_pend_kept", rd, 32'h02);
        bus_read(IDR, rd);  check_eq("m_id_none", rd, 32'h0);

        // Upper byte enables only: nothing implemented is touched.
        bus_write(MASKR, 32'hFF, 4'hE);
        bus_read(MASKR, rd); check_eq("sel_upper", rd, 32'h0);

        // Accesses outside the window are ignored and read zero.
        bus_write(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF);
        check_eq("oow_wr_dout", wr_dout, 32'h0);
        bus_write(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
        bus_read(MASKR, rd); check_eq("oow_mask", rd, 32'h0);
        bus_read(MODER, rd); check_eq("oow_mode", rd, 32'h3F);
        bus_read(BASE + 32'h18, rd); check_eq("oow_rd", rd, 32'h0);

        // 32-source instance: top source gives ID 32, reset clears everything.
        tgt = 1'b1;
        bus_write(MODER, 32'hFFFF_FFFF, 4'hF);
        bus_write(MASKR, 32'hFFFF_FFFF, 4'hF);
        src_b = 32'h8000_0000;
        tick();
        bus_read(IDR, rd); check_eq("b_id32", rd, 32'd32);
        tick();
        check_eq("b_irq", {31'h0, irq_b}, 32'h1);
        check_eq("b_int", int_b, 32'h8000_0000);
        rst_b = 1'b0;
        tick();
        check_eq("b_rst_irq", {31'h0, irq_b}, 32'h0);
        check_eq("b_rst_int", int_b, 32'h0);
        bus_read(PEND, rd);  check_eq("b_rst_pend", rd, 32'h0);
        bus_read(MASKR, rd); check_eq("b_rst_mask", rd, 32'h0);
        bus_read(IDR, rd);   check_eq("b_rst_id", rd, 32'h0);
        rst_b = 1'b1;
        tick();
        tick();
        check_eq("b_post_irq", {31'h0, irq_b}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sopc_intc.md
SOPC_INTC -- requirements
Module: sopc_intc

Interface
REQ-001 SHALL have parameter NUM_SRC, default 6, number of interrupt sources; legal range 1..32.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h2000_0000, register-window base; bits [3:0] ignored.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 src_i  input  NUM_SRC  raw interrupt sources, synchronous to clk (e.g. timer_int on bit 0).
REQ-007 ce_i  input  1  bus access enable.
REQ-008 we_i  input  1  1 = write, 0 = read.
REQ-009 addr_i  input  32  byte address.
REQ-010 sel_i  input  4  byte enables for writes; bit n covers data bits [8n+7:8n].
REQ-011 data_i  input  32  write data.
REQ-012 data_o  output  32  read data.
REQ-013 int_o  output  NUM_SRC  registered masked-pending vector, driven to CPU int_i.
REQ-014 irq_o  output  1  registered OR of int_o terms.

Function
REQ-015 Block selected when ce_i=1 and addr_i[31:4]==BASE_ADDR[31:4]; else writes ignored and data_o=0.
REQ-016 Register map by addr_i[3:2]: 0 PENDING (read / write-1-to-clear), 1 MASK (RW), 2 MODE (RW; bit=1 edge, 0 level), 3 ID (read-only; writes ignored).
REQ-017 Only bits [NUM_SRC-1:0] of PENDING, MASK and MODE exist; upper bits read 0, writes to them are ignored.
REQ-018 Writes take effect at the rising edge where selected, ce_i=1 and we_i=1, per enabled byte only.
REQ-019 Reads are combinational from current register state: data_o valid in the same cycle as ce_i/addr_i with we_i=0; data_o=0 when we_i=1.
REQ-020 src_q register holds src_i from the previous edge; edge event for bit i = src_i[i] & ~src_q[i].
REQ-021 Edge mode bit i: PENDING[i] set at the edge where an edge event occurs; cleared only by W1C write of 1; holds otherwise.
REQ-022 Edge mode, edge event and W1C of the same bit at the same edge: set wins, PENDING[i] stays 1.
REQ-023 Level mode bit i: PENDING[i] <= src_i[i] every edge; W1C has no effect.
REQ-024 MODE change level->edge: PENDING[i] keeps its current value; edge detection uses existing src_q, so no spurious event for a source already high.
REQ-025 MODE change edge->level: PENDING[i] follows src_i[i] from the same edge.
REQ-026 int_o <= PENDING & MASK at every edge, using pre-edge values (one cycle after PENDING); irq_o <= |(PENDING & MASK) at the same edge.
REQ-027 Total latency: source rising at edge k (edge mode, masked in) -> PENDING=1 after edge k -> int_o/irq_o=1 after edge k+1.
REQ-028 ID reads (index+1) of the lowest-numbered bit set in PENDING & MASK, 0 when none; combinational from current registers.
REQ-029 MASK clear of a pending bit: int_o bit drops after the next edge; PENDING is unchanged.
REQ-030 Behaviour is identical for every NUM_SRC in 1..32; no wrap-around or overflow state exists.

Reset
REQ-031 While rst=0 at an edge: PENDING, MASK, MODE, src_q, int_o, irq_o all <= 0; bus writes at that edge are ignored.
REQ-032 Reset mid-operation discards all pending events; after release, a source already high causes no edge event until it falls and rises again.
REQ-033 data_o during reset reflects the zeroed registers (reads 0 for every offset).

Verification
REQ-034 Reset, MODE=0x3F, MASK=0x01, pulse src_i[0] one cycle -> PENDING=0x01 after edge k, int_o=6'h01 and irq_o=1 after edge k+1, ID=1.
REQ-035 Then write PENDING=0x01 with sel_i=4'hF -> PENDING=0, int_o=0 one edge later; write with sel_i=4'h0 instead -> PENDING stays 0x01.
REQ-036 Edge mode bit 2, src_i[2] rises at the edge where W1C 0x04 is written -> PENDING[2]=1 (set wins).
REQ-037 Level mode, MASK=0x3F, src_i=6'b001100 held -> PENDING=0x0C, ID=3; W1C 0x0C -> PENDING remains 0x0C; src_i=0 -> PENDING=0 next edge.
REQ-038 Access with addr_i[31:4] != BASE_ADDR[31:4], we_i=1, data_i=32'hFFFF_FFFF -> no register change, data_o=0.
REQ-039 NUM_SRC=32, MASK=32'hFFFF_FFFF, edge mode, src_i[31] rising -> ID=32, irq_o=1; assert rst=0 at the next edge -> all outputs 0.
